// File: rtl/result_byte_reader.sv
// result_byte_reader: captures one product word and drains it as DATA_W-bit beats on a valid/ready stream.
// Define RESULT_BYTE_READER_PARITY_EN to add the out_parity port (even parity over the current beat).
module result_byte_reader #(
  parameter int DATA_W    = 8,
  parameter int NUM_BYTES = 2,
  parameter int MSB_FIRST = 0
) (
  input  logic                        clk,
  input  logic                        reset,
  input  logic                        in_valid,
  output logic                        in_ready,
  input  logic [DATA_W*NUM_BYTES-1:0] in_data,
  output logic                        out_valid,
  input  logic                        out_ready,
  output logic [DATA_W-1:0]           out_data,
  output logic                        out_last,
  output logic                        busy,
  output logic [7:0]                  word_cnt
`ifdef RESULT_BYTE_READER_PARITY_EN
  ,
  output logic                        out_parity
`endif
);
  localparam int IW = $clog2(NUM_BYTES);
  typedef enum logic {IDLE, SEND} state_t;
  state_t                      state_q, state_d;
  logic [IW-1:0]               idx_q, idx_d, sel;
  logic [DATA_W*NUM_BYTES-1:0] shadow_q, shadow_d;
  logic [7:0]                  cnt_q, cnt_d;
  logic                        accept, load;
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      idx_q    <= '0;
      shadow_q <= '0;
      cnt_q    <= '0;
    end else begin
      state_q  <= state_d;
      idx_q    <= idx_d;
      shadow_q <= shadow_d;
      cnt_q    <= cnt_d;
    end
  end
  // A new word may load in the same cycle the last beat of the held word is taken.
  always_comb begin
    sel       = MSB_FIRST != 0 ? IW'(NUM_BYTES - 1) - idx_q : idx_q;
    busy      = state_q == SEND;
    out_valid = busy;
    out_last  = busy && idx_q == IW'(NUM_BYTES - 1);
    out_data  = busy ? shadow_q[sel*DATA_W +: DATA_W] : '0;
    in_ready  = !busy || (out_last && out_ready);
    accept    = out_valid && out_ready;
    load      = in_valid && in_ready;
    state_d   = load ? SEND : (accept && out_last) ? IDLE : state_q;
    idx_d     = load ? '0 : (accept && !out_last) ? idx_q + 1'b1 : idx_q;
    shadow_d  = load ? in_data : shadow_q;
    cnt_d     = cnt_q + 8'(accept && out_last);
  end
  assign word_cnt = cnt_q;
`ifdef RESULT_BYTE_READER_PARITY_EN
  assign out_parity = ^out_data;
`endif
endmodule
